// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e : fetch FSM states
//   INSTR_BYTES   : PC increment per fetched word
//   NOP           : instruction word decode substitutes on a flush
//   align_word    : clears the low two address bits of a PC
package fetch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAddr  = 2'd1,
        StValid = 2'd2,
        StFault = 2'd3
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP         = 32'hD60003E0;

    function automatic logic [63:0] align_word(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_wait_ctr.sv
// Loadable 4-bit down-counter with a zero flag; times the ROM access window.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   load           : load load_value (has priority over dec)
//   load_value     : value loaded on load
//   dec            : decrement by one, saturating at zero
//   count          : current count
//   zero           : count == 0
module fetch_wait_ctr (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       dec,
    output logic [3:0] count,
    output logic       zero
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, strobes the instruction ROM, samples the
// returned word after ROM_WAIT cycles and offers it to decode over valid/ready.
// Branch redirects flush any in-flight fetch and reload the PC.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect to a target with [1:0] != 0 enters a sticky FAULT state
//               (fetch_fault = 1) that only reset clears.
//   undefined : fetch_fault port is absent; redirect_target[1:0] is forced to 0.
//
// Ports:
//   clock, reset_n     : clock, asynchronous active-low reset
//   rom_address        : ROM byte address (pc[31:0])
//   rom_data           : ROM data, only [31:0] used
//   rom_chip_select    : ROM select, high during the access window
//   rom_output_enable  : ROM drive enable, high during the access window
//   instr, instr_pc    : fetched word and its address
//   instr_valid        : instr/instr_pc valid
//   instr_ready        : decode accepts the word this cycle
//   redirect           : load redirect_target into the PC
//   redirect_target    : new PC
//   fetch_fault        : misaligned-target trap (macro builds only)
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned ROM_WAIT = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] rom_address,
    input  logic [63:0] rom_data,
    output logic        rom_chip_select,
    output logic        rom_output_enable,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
`ifdef FETCH_MISALIGN_TRAP_EN
    input  logic [63:0] redirect_target,
    output logic        fetch_fault
`else
    input  logic [63:0] redirect_target
`endif
);

    localparam logic [3:0] WAIT_LOAD = 4'(ROM_WAIT - 1);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [63:0]  instr_pc_q, instr_pc_d;

    logic         ctr_load;
    logic         ctr_dec;
    logic [3:0]   ctr_count;
    logic         ctr_zero;

    // Upper half of the ROM bus carries nothing for this stage.
    logic         unused_rom_hi;
    assign unused_rom_hi = ^rom_data[63:32];

    fetch_wait_ctr u_wait_ctr (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (ctr_load),
        .load_value (WAIT_LOAD),
        .dec        (ctr_dec),
        .count      (ctr_count),
        .zero       (ctr_zero)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            instr_pc_q <= 64'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        ctr_load   = 1'b0;
        ctr_dec    = 1'b0;

        unique case (state_q)
            StIdle: begin
                state_d  = StAddr;
                ctr_load = 1'b1;
            end
            StAddr: begin
                if (ctr_zero) begin
                    instr_d    = rom_data[31:0];
                    instr_pc_d = pc_q;
                    state_d    = StValid;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            StValid: begin
                if (instr_ready) begin
                    pc_d     = pc_q + 64'(INSTR_BYTES);
                    state_d  = StAddr;
                    ctr_load = 1'b1;
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Redirect overrides everything above; a word captured this edge is dropped,
        // while an accept in StValid has already completed on the decode side.
        if (redirect && (state_q != StFault)) begin
            instr_d    = instr_q;
            instr_pc_d = instr_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_target[1:0] != 2'b00) begin
                pc_d     = pc_q;
                state_d  = StFault;
                ctr_load = 1'b0;
                ctr_dec  = 1'b0;
            end else begin
                pc_d     = redirect_target;
                state_d  = StAddr;
                ctr_load = 1'b1;
            end
`else
            pc_d     = align_word(redirect_target);
            state_d  = StAddr;
            ctr_load = 1'b1;
`endif
        end
    end

    assign rom_address       = pc_q[31:0];
    assign rom_chip_select   = (state_q == StAddr);
    assign rom_output_enable = (state_q == StAddr);
    assign instr             = instr_q;
    assign instr_pc          = instr_pc_q;
    assign instr_valid       = (state_q == StValid);
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_fault       = (state_q == StFault);
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: one instance with ROM_WAIT=1 and one with ROM_WAIT=3,
// each driven from a combinational ROM model.
module tb_instr_fetch;

    logic        clock;
    int unsigned pass_cnt;
    int unsigned total_cnt;
    int unsigned accepts;

    // ROM_WAIT = 1 instance
    logic        reset_n;
    logic [31:0] rom_address;
    logic [63:0] rom_data;
    logic        cs, oe;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        valid, ready, redirect;
    logic [63:0] target;

    // ROM_WAIT = 3 instance
    logic        rst3;
    logic [31:0] rom_address3;
    logic [63:0] rom_data3;
    logic        cs3, oe3;
    logic [31:0] instr3;
    logic [63:0] instr_pc3;
    logic        valid3, ready3, redirect3;
    logic [63:0] target3;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fault, fault3;
`endif

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h00:  return 32'hB2001FE0;
            32'h04:  return 32'hF80FE3E0;
            32'h28:  return 32'hF1003C9F;
            default: return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    // Upper half is junk so a DUT reading it is caught.
    assign rom_data  = {32'hFFFF_FFFF, rom_word(rom_address)};
    assign rom_data3 = {32'hA5A5_A5A5, rom_word(rom_address3)};

    instr_fetch #(.RESET_PC(64'h0), .ROM_WAIT(1)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .rom_address       (rom_address),
        .rom_data          (rom_data),
        .rom_chip_select   (cs),
        .rom_output_enable (oe),
        .instr             (instr),
        .instr_pc          (instr_pc),
        .instr_valid       (valid),
        .instr_ready       (ready),
        .redirect          (redirect),
`ifdef FETCH_MISALIGN_TRAP_EN
        .redirect_target   (target),
        .fetch_fault       (fault)
`else
        .redirect_target   (target)
`endif
    );

    instr_fetch #(.RESET_PC(64'h0), .ROM_WAIT(3)) dut3 (
        .clock             (clock),
        .reset_n           (rst3),
        .rom_address       (rom_address3),
        .rom_data          (rom_data3),
        .rom_chip_select   (cs3),
        .rom_output_enable (oe3),
        .instr             (instr3),
        .instr_pc          (instr_pc3),
        .instr_valid       (valid3),
        .instr_ready       (ready3),
        .redirect          (redirect3),
`ifdef FETCH_MISALIGN_TRAP_EN
        .redirect_target   (target3),
        .fetch_fault       (fault3)
`else
        .redirect_target   (target3)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset_n && valid && ready) accepts <= accepts + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        accepts   = 0;
        reset_n   = 1'b0;
        ready     = 1'b1;
        redirect  = 1'b0;
        target    = 64'h0;
        rst3      = 1'b0;
        ready3    = 1'b1;
        redirect3 = 1'b0;
        target3   = 64'h0;

        repeat (2) @(negedge clock);
        check("rst_addr", 64'(rom_address), 64'h0);
        check("rst_cs", 64'(cs), 64'h0);
        check("rst_oe", 64'(oe), 64'h0);
        check("rst_instr", 64'(instr), 64'h0);
        check("rst_instr_pc", instr_pc, 64'h0);
        check("rst_valid", 64'(valid), 64'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("rst_fault", 64'(fault), 64'h0);
`endif

        // Release: cycle 0 IDLE, cycle 1 ADDR, cycle 2 VALID.
        reset_n = 1'b1;
        @(negedge clock);
        check("c1_cs", 64'(cs), 64'h1);
        check("c1_oe", 64'(oe), 64'h1);
        check("c1_addr", 64'(rom_address), 64'h0);
        check("c1_valid", 64'(valid), 64'h0);
        @(negedge clock);
        check("c2_valid", 64'(valid), 64'h1);
        check("c2_instr_pc", instr_pc, 64'h0);
        check("c2_instr", 64'(instr), 64'hB2001FE0);
        check("c2_cs", 64'(cs), 64'h0);
        @(negedge clock);
        check("c3_cs", 64'(cs), 64'h1);
        check("c3_addr", 64'(rom_address), 64'h4);
        check("c3_valid", 64'(valid), 64'h0);
        @(negedge clock);
        check("c4_valid", 64'(valid), 64'h1);
        check("c4_instr_pc", instr_pc, 64'h4);
        check("c4_instr", 64'(instr), 64'hF80FE3E0);

        // Stall decode for five cycles.
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("stall_valid", 64'(valid), 64'h1);
            check("stall_instr_pc", instr_pc, 64'h4);
            check("stall_instr", 64'(instr), 64'hF80FE3E0);
            check("stall_cs", 64'(cs), 64'h0);
            check("stall_oe", 64'(oe), 64'h0);
            check("stall_addr", 64'(rom_address), 64'h4);
        end
        ready = 1'b1;
        @(negedge clock);
        check("post_stall_cs", 64'(cs), 64'h1);
        check("post_stall_addr", 64'(rom_address), 64'h8);
        check("post_stall_valid", 64'(valid), 64'h0);

        // Redirect during ADDR drops the fetch at 0x8.
        redirect = 1'b1;
        target   = 64'h28;
        @(negedge clock);
        redirect = 1'b0;
        check("redir_addr", 64'(rom_address), 64'h28);
        check("redir_cs", 64'(cs), 64'h1);
        check("redir_valid", 64'(valid), 64'h0);
        @(negedge clock);
        check("redir_word_valid", 64'(valid), 64'h1);
        check("redir_word_pc", instr_pc, 64'h28);
        check("redir_word", 64'(instr), 64'hF1003C9F);

        // Redirect coinciding with an accept.
        redirect = 1'b1;
        target   = 64'h58;
        @(negedge clock);
        redirect = 1'b0;
        check("acc_redir_valid", 64'(valid), 64'h0);
        check("acc_redir_addr", 64'(rom_address), 64'h58);
        check("acc_redir_cs", 64'(cs), 64'h1);
        @(negedge clock);
        check("acc_redir_word_valid", 64'(valid), 64'h1);
        check("acc_redir_word_pc", instr_pc, 64'h58);
        check("acc_redir_word", 64'(instr), 64'hC0DE0058);
        ready = 1'b0;
        @(negedge clock);
        check("accept_count", 64'(accepts), 64'd3);

        // Misaligned redirect.
        redirect = 1'b1;
        target   = 64'h2A;
        @(negedge clock);
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_fault", 64'(fault), 64'h1);
        check("mis_valid", 64'(valid), 64'h0);
        check("mis_cs", 64'(cs), 64'h0);
        redirect = 1'b1;
        target   = 64'h30;
        @(negedge clock);
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("fault_hold", 64'(fault), 64'h1);
            check("fault_cs", 64'(cs), 64'h0);
            check("fault_oe", 64'(oe), 64'h0);
            check("fault_valid", 64'(valid), 64'h0);
        end
`else
        check("mis_addr", 64'(rom_address), 64'h28);
        check("mis_cs", 64'(cs), 64'h1);
        @(negedge clock);
        check("mis_valid", 64'(valid), 64'h1);
        check("mis_instr_pc", instr_pc, 64'h28);
        check("mis_instr", 64'(instr), 64'hF1003C9F);
`endif

        // ROM_WAIT = 3: reset pulsed during the second wait cycle.
        @(negedge clock);
        rst3 = 1'b1;
        @(negedge clock);
        check("w3_c1_cs", 64'(cs3), 64'h1);
        @(negedge clock);
        check("w3_c2_cs", 64'(cs3), 64'h1);
        check("w3_c2_valid", 64'(valid3), 64'h0);
        rst3 = 1'b0;
        #1;
        check("w3_rst_cs", 64'(cs3), 64'h0);
        check("w3_rst_oe", 64'(oe3), 64'h0);
        check("w3_rst_valid", 64'(valid3), 64'h0);
        check("w3_rst_addr", 64'(rom_address3), 64'h0);
        check("w3_rst_instr", 64'(instr3), 64'h0);
        check("w3_rst_instr_pc", instr_pc3, 64'h0);
        @(negedge clock);
        rst3 = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            check("w3_wait_cs", 64'(cs3), 64'h1);
            check("w3_wait_valid", 64'(valid3), 64'h0);
        end
        @(negedge clock);
        check("w3_c4_valid", 64'(valid3), 64'h1);
        check("w3_c4_instr_pc", instr_pc3, 64'h0);
        check("w3_c4_instr", 64'(instr3), 64'hB2001FE0);
        check("w3_c4_cs", 64'(cs3), 64'h0);
        repeat (3) @(negedge clock);
        check("w3_c7_valid", 64'(valid3), 64'h0);
        @(negedge clock);
        check("w3_c8_valid", 64'(valid3), 64'h1);
        check("w3_c8_instr_pc", instr_pc3, 64'h4);
        check("w3_c8_instr", 64'(instr3), 64'hF80FE3E0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
